register_file_mp: RTL and testbench

Parametrised multi-port register file for the decode stage, successor to the fixed two-read-port file. Adds a configurable register count (32 for RV32I, 16 for RV32E), configurable read-port count, a post-reset zeroing sweep with a ready flag, and a per-register busy scoreboard that tells the hazard unit whether a source operand is still in flight. It sits in decode: read addresses come from the instruction fields, the write port from writeback, and issue/flush from the hazard unit.

---
 rtl/register_file_mp.sv | 145 ++++++++++++++
 tb/tb_register_file_mp.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// register_file_mp: multi-port decode-stage register file with a zeroing sweep and an operand scoreboard.
// The scoreboard is built only when RF_SCOREBOARD_EN is defined; otherwise REG_R_Busy is tied to 0.
module register_file_mp #(
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int XLEN         = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_RD_PORTS*5-1:0]    REG_R_Addr,
  output logic [NUM_RD_PORTS*XLEN-1:0] REG_R_Data,
  output logic [NUM_RD_PORTS-1:0]      REG_R_Busy,
  input  logic                         REG_W_En,
  input  logic [4:0]                   REG_W_Addr,
  input  logic [XLEN-1:0]              REG_W_Data,
  input  logic                         Issue_En,
  input  logic [4:0]                   Issue_RD,
  input  logic                         Flush,
  output logic                         Init_Done
);

  localparam int         AW = $clog2(NUM_REGS);
  localparam logic [5:0] NR = 6'(NUM_REGS);
  localparam logic [4:0] LAST = 5'(NUM_REGS - 1);

  typedef enum logic {
    INIT,
    READY
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [4:0]      cnt;
  logic [4:0]      cnt_nx;
  logic            sweep_we;
  logic            ready;
  logic            w_ok;
  logic [XLEN-1:0] regs [NUM_REGS];

  // x0 and anything past the architectural count are not real registers
  function automatic logic valid_addr(input logic [4:0] a);
    return (a != 5'd0) && ({1'b0, a} < NR);
  endfunction

  assign ready     = (state == READY);
  assign Init_Done = ready;
  assign w_ok      = ready && REG_W_En && valid_addr(REG_W_Addr);

  // state and sweep counter; reset restarts the sweep at x1
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= INIT;
      cnt   <= 5'd1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // sweep sequencing: one register per cycle, leave INIT after the last one
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sweep_we = 1'b0;
    unique case (state)
      INIT: begin
        sweep_we = 1'b1;
        cnt_nx   = cnt + 5'd1;
        if (cnt == LAST) begin
          state_nx = READY;
        end
      end
      READY: begin
        cnt_nx = cnt;
      end
      default: begin
        state_nx = INIT;
      end
    endcase
  end

  // storage: the sweep owns the array in INIT, writeback owns it in READY
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (sweep_we) begin
        regs[cnt[AW-1:0]] <= '0;
      end else if (w_ok) begin
        regs[REG_W_Addr[AW-1:0]] <= REG_W_Data;
      end
    end
  end

`ifdef RF_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy;
  logic                iss_ok;

  assign iss_ok = ready && Issue_En && valid_addr(Issue_RD);

  // scoreboard: flush clears all, otherwise a new producer beats a retiring one
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy <= '0;
    end else if (ready) begin
      if (Flush) begin
        busy <= '0;
      end else begin
        if (w_ok) begin
          busy[REG_W_Addr[AW-1:0]] <= 1'b0;
        end
        if (iss_ok) begin
          busy[Issue_RD[AW-1:0]] <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_sb;
  assign unused_sb = ^{Issue_En, Issue_RD, Flush};
`endif

  // read ports: zero for x0/out-of-range/INIT, writeback bypass, then storage
  always_comb begin
    logic [4:0] a;
    logic       hit;
    REG_R_Data = '0;
    REG_R_Busy = '0;
    a          = '0;
    hit        = 1'b0;
    for (int i = 0; i < NUM_RD_PORTS; i++) begin
      a   = REG_R_Addr[5*i +: 5];
      hit = REG_W_En && (REG_W_Addr == a);
      if (ready && valid_addr(a)) begin
        if (hit) begin
          REG_R_Data[XLEN*i +: XLEN] = REG_W_Data;
        end else begin
          REG_R_Data[XLEN*i +: XLEN] = regs[a[AW-1:0]];
        end
`ifdef RF_SCOREBOARD_EN
        REG_R_Busy[i] = busy[a[AW-1:0]] && !hit;
`endif
      end
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed checks of sweep, bypass, bounds and scoreboard.
// Expected busy values follow RF_SCOREBOARD_EN; data expectations are identical either way.
module tb_register_file_mp;

`ifdef RF_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic        clk;
  int          total;
  int          bad;
  int          n;

  logic        rst;
  logic [14:0] r_addr;
  logic [95:0] r_data;
  logic [2:0]  r_busy;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        iss_en;
  logic [4:0]  iss_rd;
  logic        flush;
  logic        done;

  logic        rst16;
  logic [9:0]  r_addr16;
  logic [63:0] r_data16;
  logic [1:0]  r_busy16;
  logic        w_en16;
  logic [4:0]  w_addr16;
  logic [31:0] w_data16;
  logic        iss_en16;
  logic [4:0]  iss_rd16;
  logic        flush16;
  logic        done16;

  register_file_mp #(
    .NUM_REGS(32),
    .NUM_RD_PORTS(3),
    .XLEN(32)
  ) u32 (
    .CLK(clk),
    .RST(rst),
    .REG_R_Addr(r_addr),
    .REG_R_Data(r_data),
    .REG_R_Busy(r_busy),
    .REG_W_En(w_en),
    .REG_W_Addr(w_addr),
    .REG_W_Data(w_data),
    .Issue_En(iss_en),
    .Issue_RD(iss_rd),
    .Flush(flush),
    .Init_Done(done)
  );

  register_file_mp #(
    .NUM_REGS(16),
    .NUM_RD_PORTS(2),
    .XLEN(32)
  ) u16 (
    .CLK(clk),
    .RST(rst16),
    .REG_R_Addr(r_addr16),
    .REG_R_Data(r_data16),
    .REG_R_Busy(r_busy16),
    .REG_W_En(w_en16),
    .REG_W_Addr(w_addr16),
    .REG_W_Data(w_data16),
    .Issue_En(iss_en16),
    .Issue_RD(iss_rd16),
    .Flush(flush16),
    .Init_Done(done16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int i);
    return r_data[32*i +: 32];
  endfunction

  function automatic logic [31:0] rd16(input int i);
    return r_data16[32*i +: 32];
  endfunction

  function automatic logic [14:0] addr3(input logic [4:0] a0,
                                        input logic [4:0] a1,
                                        input logic [4:0] a2);
    return {a2, a1, a0};
  endfunction

  task automatic wait_done32();
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_done16();
    n = 0;
    while (!done16 && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; r_addr = '0; w_en = 1'b0; w_addr = '0; w_data = '0;
    iss_en = 1'b0; iss_rd = '0; flush = 1'b0;
    rst16 = 1'b1; r_addr16 = '0; w_en16 = 1'b0; w_addr16 = '0;
    w_data16 = '0; iss_en16 = 1'b0; iss_rd16 = '0; flush16 = 1'b0;

    // reset state
    tick();
    r_addr = addr3(5'd5, 5'd1, 5'd31);
    mid();
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_data0", rd(0), 32'd0);
    chk("rst_data2", rd(2), 32'd0);
    chk("rst_busy", {29'd0, r_busy}, 32'd0);
    tick();
    rst = 1'b0;
    wait_done32();
    chk("sweep_len_a", n, 32'd31);

    // preload x5, then a reset must wipe it
    w_en = 1'b1; w_addr = 5'd5; w_data = 32'hDEADBEEF;
    r_addr = addr3(5'd5, 5'd5, 5'd5);
    mid();
    chk("pre_bypass", rd(0), 32'hDEADBEEF);
    tick();
    w_en = 1'b0;
    mid();
    chk("pre_store", rd(1), 32'hDEADBEEF);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mid();
    chk("init_read0", rd(0), 32'd0);
    chk("init_done0", {31'd0, done}, 32'd0);
    wait_done32();
    chk("sweep_len_b", n, 32'd31);
    mid();
    chk("x5_zeroed", rd(2), 32'd0);

    // reset in the middle of the sweep restarts it fully
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (9) tick();
    chk("mid_sweep_done", {31'd0, done}, 32'd0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    wait_done32();
    chk("sweep_len_restart", n, 32'd31);

    // same-cycle bypass on all three ports
    w_en = 1'b1; w_addr = 5'd7; w_data = 32'h12345678;
    r_addr = addr3(5'd7, 5'd7, 5'd7);
    mid();
    chk("byp_p0", rd(0), 32'h12345678);
    chk("byp_p1", rd(1), 32'h12345678);
    chk("byp_p2", rd(2), 32'h12345678);
    tick();
    w_en = 1'b0;
    mid();
    chk("x7_store", rd(1), 32'h12345678);
    tick();

    // x0 is hardwired to zero
    w_en = 1'b1; w_addr = 5'd0; w_data = 32'hFFFFFFFF;
    r_addr = addr3(5'd0, 5'd0, 5'd0);
    mid();
    chk("x0_byp", rd(0), 32'd0);
    tick();
    w_en = 1'b0;
    mid();
    chk("x0_store", rd(2), 32'd0);
    tick();

    // issue x3 then read it
    iss_en = 1'b1; iss_rd = 5'd3;
    r_addr = addr3(5'd3, 5'd7, 5'd0);
    mid();
    chk("x3_busy_pre", {31'd0, r_busy[0]}, 32'd0);
    tick();
    iss_en = 1'b0;
    mid();
    chk("x3_busy", {29'd0, r_busy}, {31'd0, SB});

    // writeback x3 clears busy and bypasses data
    tick();
    w_en = 1'b1; w_addr = 5'd3; w_data = 32'h55;
    mid();
    chk("x3_wb_busy", {31'd0, r_busy[0]}, 32'd0);
    chk("x3_wb_data", rd(0), 32'h55);
    tick();
    w_en = 1'b0;
    mid();
    chk("x3_after_busy", {31'd0, r_busy[0]}, 32'd0);
    chk("x3_after_data", rd(0), 32'h55);

    // same-cycle issue and writeback of x4: set wins
    tick();
    iss_en = 1'b1; iss_rd = 5'd4;
    w_en = 1'b1; w_addr = 5'd4; w_data = 32'h44;
    r_addr = addr3(5'd4, 5'd0, 5'd0);
    tick();
    iss_en = 1'b0; w_en = 1'b0;
    mid();
    chk("x4_busy", {31'd0, r_busy[0]}, {31'd0, SB});
    chk("x4_data", rd(0), 32'h44);

    // flush beats a same-cycle issue
    tick();
    iss_en = 1'b1; iss_rd = 5'd1;
    tick();
    iss_rd = 5'd2;
    tick();
    iss_en = 1'b0;
    r_addr = addr3(5'd1, 5'd2, 5'd6);
    mid();
    chk("x1x2_busy", {29'd0, r_busy}, {29'd0, 1'b0, SB, SB});
    tick();
    flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd6;
    tick();
    flush = 1'b0; iss_en = 1'b0;
    mid();
    chk("flush_busy", {29'd0, r_busy}, 32'd0);
    r_addr = addr3(5'd4, 5'd3, 5'd7);
    #1;
    chk("flush_x4", {31'd0, r_busy[0]}, 32'd0);
    chk("flush_data", rd(2), 32'h12345678);

    // RV32E bounds on the 16-register instance
    tick();
    rst16 = 1'b0;
    wait_done16();
    chk("sweep16_len", n, 32'd15);
    w_en16 = 1'b1; w_addr16 = 5'd20; w_data16 = 32'hAAAA5555;
    iss_en16 = 1'b1; iss_rd16 = 5'd20;
    r_addr16 = {5'd4, 5'd20};
    mid();
    chk("x20_byp", rd16(0), 32'd0);
    chk("x20_busy_now", {30'd0, r_busy16}, 32'd0);
    tick();
    w_en16 = 1'b0; iss_en16 = 1'b0;
    mid();
    chk("x20_read", rd16(0), 32'd0);
    chk("x4_alias", rd16(1), 32'd0);
    chk("x20_busy", {30'd0, r_busy16}, 32'd0);
    tick();
    w_en16 = 1'b1; w_addr16 = 5'd15; w_data16 = 32'h1111;
    iss_en16 = 1'b1; iss_rd16 = 5'd15;
    tick();
    w_en16 = 1'b0; iss_en16 = 1'b0;
    r_addr16 = {5'd16, 5'd15};
    mid();
    chk("x15_data", rd16(0), 32'h1111);
    chk("x15_busy", {31'd0, r_busy16[0]}, {31'd0, SB});
    chk("x16_data", rd16(1), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
